// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one 8N1 UART transmit line among NREQ byte sources.
// Arbitrates in IDLE, latches the winner's byte, then shifts the frame out on baud ticks.
module uart_tx_sched #(
  parameter int NREQ   = 4,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     tick,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*DATA_W-1:0]   data,
  output logic [NREQ-1:0]          ack,
  output logic [$clog2(NREQ)-1:0]  grant_id,
  output logic                     busy,
  output logic                     tx
);

  localparam int IW = $clog2(NREQ);
  localparam int BW = $clog2(DATA_W);
  localparam logic [IW-1:0] LAST_ID  = IW'(NREQ - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    START,
    DATA,
    STOP
  } state_t;

  state_t            state, state_n;
  logic [IW-1:0]     last, last_n;
  logic [IW-1:0]     grant_n;
  logic [IW-1:0]     win, cand;
  logic              found;
  logic [DATA_W-1:0] shreg, shreg_n;
  logic [BW-1:0]     bitcnt, bitcnt_n;
  logic [NREQ-1:0]   ack_n;
  logic              busy_n;
  logic              tx_n;
  logic [DATA_W-1:0] lanes [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_lane
    assign lanes[g] = data[g*DATA_W +: DATA_W];
  end

  // Search starts one past the previous winner and wraps, so every client gets a turn.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = last;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = (cand == LAST_ID) ? '0 : cand + 1'b1;
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    state_n  = state;
    last_n   = last;
    grant_n  = grant_id;
    shreg_n  = shreg;
    bitcnt_n = bitcnt;
    ack_n    = '0;
    busy_n   = busy;
    tx_n     = tx;
    case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (found) begin
          ack_n[win] = 1'b1;
          grant_n    = win;
          last_n     = win;
          shreg_n    = lanes[win];
          busy_n     = 1'b1;
          state_n    = ALIGN;
        end
      end
      ALIGN: begin
        if (tick) begin
          tx_n    = 1'b0;
          state_n = START;
        end
      end
      START: begin
        if (tick) begin
          tx_n     = shreg[0];
          shreg_n  = {1'b0, shreg[DATA_W-1:1]};
          bitcnt_n = '0;
          state_n  = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          if (bitcnt == LAST_BIT) begin
            tx_n    = 1'b1;
            state_n = STOP;
          end else begin
            tx_n     = shreg[0];
            shreg_n  = {1'b0, shreg[DATA_W-1:1]};
            bitcnt_n = bitcnt + 1'b1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          busy_n  = 1'b0;
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      last     <= LAST_ID;
      grant_id <= '0;
      shreg    <= '0;
      bitcnt   <= '0;
      ack      <= '0;
      busy     <= 1'b0;
      tx       <= 1'b1;
    end else begin
      state    <= state_n;
      last     <= last_n;
      grant_id <= grant_n;
      shreg    <= shreg_n;
      bitcnt   <= bitcnt_n;
      ack      <= ack_n;
      busy     <= busy_n;
      tx       <= tx_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: frame bit timing, round-robin order, reset abort, tick alignment.
module tb_uart_tx_sched;

  localparam int P = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick;
  logic [3:0]  req;
  logic [31:0] data;
  logic [3:0]  ack;
  logic [1:0]  grant_id;
  logic        busy;
  logic        tx;

  int checks = 0;
  int errors = 0;
  int tphase = 0;
  int n;

  uart_tx_sched #(.NREQ(4), .DATA_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .req      (req),
    .data     (data),
    .ack      (ack),
    .grant_id (grant_id),
    .busy     (busy),
    .tx       (tx)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: drive this cycle's tick from the bench's baud phase, sample 1 ns after the edge.
  task automatic cyc();
    tick   = (tphase == P-1);
    tphase = (tphase == P-1) ? 0 : tphase + 1;
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input logic [7:0] b, input logic [1:0] id, input logic [3:0] clr,
                           input logic [3:0] raise, output int nwait);
    int w;
    int expw;
    logic ok;
    logic exp;
    nwait = 0;
    while (ack === 4'b0 && nwait < 60) begin
      cyc();
      nwait++;
    end
    chk("ack", {28'b0, ack}, 32'(4'b1 << id));
    chk("grant_id", {30'b0, grant_id}, {30'b0, id});
    chk("busy_on", {31'b0, busy}, 1);
    expw = P - tphase;
    req  = req & ~clr;
    w = 0;
    cyc();
    w++;
    chk("ack_pulse", {28'b0, ack}, 0);
    while (tx !== 1'b0 && w < 2*P+5) begin
      cyc();
      w++;
    end
    chk("align_wait", w, expw);
    for (int k = 0; k < 10; k++) begin
      if (k == 0)      exp = 1'b0;
      else if (k == 9) exp = 1'b1;
      else             exp = b[k-1];
      ok = 1'b1;
      for (int c = 0; c < P; c++) begin
        if (k == 4 && c == 0) req = req | raise;
        if (tx !== exp || busy !== 1'b1 || ack !== 4'b0) ok = 1'b0;
        cyc();
      end
      chk($sformatf("bit%0d_of_%0h", k, b), {31'b0, ok}, 1);
    end
    chk("busy_off", {31'b0, busy}, 0);
    chk("tx_idle", {31'b0, tx}, 1);
  endtask

  initial begin
    rst  = 1'b1;
    tick = 1'b0;
    req  = 4'b0;
    data = 32'h0;
    cyc();
    cyc();
    chk("rst_tx", {31'b0, tx}, 1);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_ack", {28'b0, ack}, 0);
    chk("rst_grant", {30'b0, grant_id}, 0);
    rst = 1'b0;
    cyc();
    chk("idle_tx", {31'b0, tx}, 1);

    // Single request, byte 0xA5, req dropped right after ack
    data   = {8'h00, 8'h00, 8'h00, 8'hA5};
    tphase = 0;
    req    = 4'b0001;
    run_frame(8'hA5, 2'd0, 4'b0001, 4'b0, n);
    for (int i = 0; i < 5; i++) cyc();
    chk("idle_no_ack", {28'b0, ack}, 0);
    chk("idle_tx_after", {31'b0, tx}, 1);
    chk("idle_grant_held", {30'b0, grant_id}, 0);

    // Simultaneous request after reset: client 1 then client 2
    rst = 1'b1;
    cyc();
    rst  = 1'b0;
    data = {8'h00, 8'hC3, 8'h81, 8'h00};
    req  = 4'b0110;
    run_frame(8'h81, 2'd1, 4'b0010, 4'b0, n);
    run_frame(8'hC3, 2'd2, 4'b0100, 4'b0, n);
    chk("b2b_gap_sim", n, 1);

    // Fairness with all four held: 0,1,2,3,0
    rst = 1'b1;
    cyc();
    rst  = 1'b0;
    data = {8'h44, 8'h33, 8'h22, 8'h11};
    req  = 4'b1111;
    run_frame(8'h11, 2'd0, 4'b0000, 4'b0, n);
    run_frame(8'h22, 2'd1, 4'b0000, 4'b0, n);
    chk("b2b_gap_1", n, 1);
    run_frame(8'h33, 2'd2, 4'b0000, 4'b0, n);
    chk("b2b_gap_2", n, 1);
    run_frame(8'h44, 2'd3, 4'b0000, 4'b0, n);
    chk("b2b_gap_3", n, 1);
    run_frame(8'h11, 2'd0, 4'b1111, 4'b0, n);
    chk("b2b_gap_wrap", n, 1);

    // Client 3 requests mid-frame of client 0
    data = {8'h96, 8'h00, 8'h00, 8'h3C};
    req  = 4'b0001;
    run_frame(8'h3C, 2'd0, 4'b0001, 4'b1000, n);
    run_frame(8'h96, 2'd3, 4'b1000, 4'b0, n);
    chk("busy_req_gap", n, 1);

    // Reset during data bit 4, then a clean resend
    data = {8'h00, 8'h00, 8'h00, 8'h0F};
    req  = 4'b0001;
    n = 0;
    while (ack === 4'b0 && n < 60) begin cyc(); n++; end
    chk("abort_ack", {28'b0, ack}, 4'b0001);
    n = 0;
    while (tx !== 1'b0 && n < 2*P+5) begin cyc(); n++; end
    for (int i = 0; i < 5*P + P/2; i++) cyc();
    chk("abort_bit4", {31'b0, tx}, 0);
    chk("abort_busy_pre", {31'b0, busy}, 1);
    rst = 1'b1;
    #1;
    chk("abort_tx", {31'b0, tx}, 1);
    chk("abort_busy", {31'b0, busy}, 0);
    chk("abort_ack_clr", {28'b0, ack}, 0);
    cyc();
    cyc();
    rst = 1'b0;
    run_frame(8'h0F, 2'd0, 4'b0001, 4'b0, n);
    chk("resend_gap", n, 1);

    // Tick in the arbitration cycle must not start the frame early
    for (int i = 0; i < 3; i++) cyc();
    data   = {8'h00, 8'h00, 8'h00, 8'h5A};
    tphase = P-1;
    req    = 4'b0001;
    run_frame(8'h5A, 2'd0, 4'b0001, 4'b0, n);
    chk("coincident_gap", n, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
